// File: rtl/fp_div_top.sv
// Iterative FP32 divider: one restoring-division step per cycle, valid/ready on both sides.
// Optional build macro FP_DIV_GRS_EN adds guard/sticky outputs exposing the pre-rounding bits.

package fp_div_pkg;
  typedef enum logic [2:0] {
    IEEE_near,
    IEEE_zero,
    IEEE_pinf,
    IEEE_ninf,
    near_up,
    away_zero
  } round_values;
endpackage

module fp_div_top
  import fp_div_pkg::*;
#(
  parameter round_values rnd = IEEE_near
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] z,
`ifdef FP_DIV_GRS_EN
  output logic        guard,
  output logic        sticky,
`endif
  output logic [7:0]  status
);

  typedef enum logic [1:0] {IDLE, DIV, RND, DONE} state_t;

  state_t state, state_next;

  // Operand decode; exponent 0 (including denormals) is treated as signed zero.
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic        sign_in, is_special, accept;
  logic [31:0] special_z;
  logic [7:0]  special_status;

  assign ea      = a[30:23];
  assign eb      = b[30:23];
  assign fa      = a[22:0];
  assign fb      = b[22:0];
  assign a_zero  = (ea == 8'h00);
  assign b_zero  = (eb == 8'h00);
  assign a_inf   = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf   = (eb == 8'hFF) && (fb == 23'd0);
  assign a_nan   = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan   = (eb == 8'hFF) && (fb != 23'd0);
  assign sign_in = a[31] ^ b[31];

  assign is_special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
  assign accept     = (state == IDLE) && in_valid;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    special_z      = {sign_in, 31'd0};
    special_status = 8'h01;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      special_z      = 32'h7FC0_0000;
      special_status = 8'h04;
    end else if (a_inf) begin
      special_z      = {sign_in, 8'hFF, 23'd0};
      special_status = 8'h02;
    end else if (b_zero) begin
      special_z      = {sign_in, 8'hFF, 23'd0};
      special_status = 8'h42;
    end
  end

  // Datapath registers
  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [23:0]       mb_q;
  logic [24:0]       rem_q;
  logic [25:0]       quo_q;
  logic [4:0]        count_q;

  logic        rem_ge;
  logic [24:0] rem_sub;

  assign rem_ge  = (rem_q >= {1'b0, mb_q});
  assign rem_sub = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;

  // NOTE: state and outputs are reset; the datapath is always reloaded on accept, so it needs no reset.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      sign_q  <= sign_in;
      exp_q   <= $signed({2'b00, ea} - {2'b00, eb} + 10'd127);
      mb_q    <= {1'b1, fb};
      rem_q   <= {2'b01, fa};
      quo_q   <= 26'd0;
      count_q <= 5'd25;
    end else if (state == DIV) begin
      rem_q   <= {rem_sub[23:0], 1'b0};
      quo_q   <= {quo_q[24:0], rem_ge};
      count_q <= count_q - 5'd1;
    end
  end

  // Normalize, round and range-check the finished quotient.
  logic [23:0]       mant;
  logic              rnd_guard, rnd_sticky, rnd_inc;
  logic [24:0]       mant_sum;
  logic [22:0]       frac_fin;
  logic signed [9:0] exp_norm, exp_fin;
  logic              dir_up, ovf_inf, unf_min;
  logic [31:0]       rnd_z;
  logic [7:0]        rnd_status;

  always_comb begin
    if (quo_q[25]) begin
      mant       = quo_q[25:2];
      rnd_guard  = quo_q[1];
      rnd_sticky = quo_q[0] | (rem_q != 25'd0);
      exp_norm   = exp_q;
    end else begin
      mant       = quo_q[24:1];
      rnd_guard  = quo_q[0];
      rnd_sticky = (rem_q != 25'd0);
      exp_norm   = exp_q - 10'sd1;
    end

    dir_up = ((rnd == IEEE_pinf) && !sign_q) || ((rnd == IEEE_ninf) && sign_q);

    case (rnd)
      IEEE_near: rnd_inc = rnd_guard & (rnd_sticky | mant[0]);
      near_up:   rnd_inc = rnd_guard;
      away_zero: rnd_inc = rnd_guard | rnd_sticky;
      IEEE_pinf,
      IEEE_ninf: rnd_inc = dir_up & (rnd_guard | rnd_sticky);
      default:   rnd_inc = 1'b0;
    endcase

    mant_sum = {1'b0, mant} + {24'd0, rnd_inc};
    if (mant_sum[24]) begin
      frac_fin = 23'd0;
      exp_fin  = exp_norm + 10'sd1;
    end else begin
      frac_fin = mant_sum[22:0];
      exp_fin  = exp_norm;
    end

    ovf_inf = (rnd == IEEE_near) || (rnd == near_up) || (rnd == away_zero) || dir_up;
    unf_min = (rnd == away_zero) || dir_up;

    rnd_z      = {sign_q, exp_fin[7:0], frac_fin};
    rnd_status = {2'b00, rnd_guard | rnd_sticky, 5'b00000};
    if (exp_fin >= 10'sd255) begin
      rnd_z      = ovf_inf ? {sign_q, 8'hFF, 23'd0} : {sign_q, 31'h7F7F_FFFF};
      rnd_status = {4'b0011, 2'b00, ovf_inf, 1'b0};
    end else if (exp_fin <= 10'sd0) begin
      rnd_z      = unf_min ? {sign_q, 31'h0080_0000} : {sign_q, 31'd0};
      rnd_status = {4'b0010, 1'b1, 2'b00, ~unf_min};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = is_special ? DONE : DIV;
      end
      DIV:  if (count_q == 5'd0) state_next = RND;
      RND:  state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z      <= 32'd0;
      status <= 8'd0;
    end else if (accept && is_special) begin
      z      <= special_z;
      status <= special_status;
    end else if (state == RND) begin
      z      <= rnd_z;
      status <= rnd_status;
    end
  end

`ifdef FP_DIV_GRS_EN
  always_ff @(posedge clk) begin
    if (rst || (accept && is_special)) begin
      guard  <= 1'b0;
      sticky <= 1'b0;
    end else if (state == RND) begin
      guard  <= rnd_guard;
      sticky <= rnd_sticky;
    end
  end
`else
`endif

endmodule
